// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the LemonPC register file: picks EXU or LSU for the
// single write port, registers the write, and tracks per-register pending writes.
module rf_wb_arbiter #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 64,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  exu_valid,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    output logic                  exu_ready,
    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0] rf_data
);

    localparam int         NREG       = 1 << ADDR_WIDTH;
    localparam logic [3:0] STARVE_THR = 4'(STARVE_LIMIT);

    logic [NREG-1:0]       r_busy;
    logic [NREG-1:0]       w_busy_nxt;
    logic [3:0]            r_starve_cnt;
    logic                  r_rf_wen;
    logic [ADDR_WIDTH-1:0] r_rf_rd;
    logic [DATA_WIDTH-1:0] r_rf_data;

    logic                  w_exu_pri;
    logic                  w_lsu_gnt;
    logic                  w_exu_gnt;
    logic                  w_any_gnt;
    logic                  w_issue_fire;
    logic [ADDR_WIDTH-1:0] w_gnt_rd;
    logic [DATA_WIDTH-1:0] w_gnt_data;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? 4'hF : v + 4'd1;
    endfunction

    // LSU wins by default; a starved EXU takes one grant
    assign w_exu_pri  = exu_valid && (r_starve_cnt >= STARVE_THR);
    assign w_lsu_gnt  = lsu_valid && !w_exu_pri;
    assign w_exu_gnt  = exu_valid && !w_lsu_gnt;
    assign w_any_gnt  = w_exu_gnt || w_lsu_gnt;
    assign w_gnt_rd   = w_exu_gnt ? exu_rd   : lsu_rd;
    assign w_gnt_data = w_exu_gnt ? exu_data : lsu_data;

    assign exu_ready  = w_exu_gnt;
    assign lsu_ready  = w_lsu_gnt;

    assign issue_ready  = !r_busy[issue_rd];
    assign rs1_busy     = r_busy[rs1];
    assign rs2_busy     = r_busy[rs2];
    assign w_issue_fire = issue_valid && issue_ready && (issue_rd != '0);

    assign rf_wen  = r_rf_wen;
    assign rf_rd   = r_rf_rd;
    assign rf_data = r_rf_data;

    // A new producer's set overrides the commit's clear on the same register
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_rf_wen) begin
            w_busy_nxt[r_rf_rd] = 1'b0;
        end
        if (w_issue_fire) begin
            w_busy_nxt[issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy       <= '0;
            r_starve_cnt <= 4'd0;
            r_rf_wen     <= 1'b0;
            r_rf_rd      <= '0;
            r_rf_data    <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (exu_valid && !w_exu_gnt) begin
                r_starve_cnt <= sat_inc4(r_starve_cnt);
            end else begin
                r_starve_cnt <= 4'd0;
            end
            // Writes to x0 complete the handshake but never reach the file
            if (w_any_gnt) begin
                r_rf_wen  <= (w_gnt_rd != '0);
                r_rf_rd   <= w_gnt_rd;
                r_rf_data <= w_gnt_data;
            end else begin
                r_rf_wen <= 1'b0;
            end
        end
    end

endmodule
